id_stage_pipe: RTL and testbench



---
 rtl/id_stage_pipe_pkg.sv | 43 ++++
 rtl/id_regfile.sv | 36 +++
 rtl/id_stage_pipe.sv | 121 ++++++++++++
 tb/tb_id_stage_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - MIPS opcode/funct constants and instruction field split
package id_stage_pipe_pkg;

  localparam logic [5:0] R_FORM = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] JR     = 6'h08;
  localparam logic [5:0] JALR   = 6'h09;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } ins_fields_t;

  function automatic ins_fields_t split_ins(input logic [31:0] ins);
    ins_fields_t f;
    f.op    = ins[31:26];
    f.rs    = ins[25:21];
    f.rt    = ins[20:16];
    f.rd    = ins[15:11];
    f.shamt = ins[10:6];
    f.funct = ins[5:0];
    f.imm   = ins[15:0];
    return f;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - two-read/one-write register file with write-to-read bypass
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RA_W = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Register 0 is hardwired: never bypassed, never read from storage
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS decode stage with load-use stall, flush and ID/EX handshake
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RA_W = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ld,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata1,
  output logic [XLEN-1:0] out_rdata2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc4,
  output logic [RA_W-1:0] out_wadr,
  output logic            out_we,
  output logic [5:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [4:0]      out_shamt
);

  import id_stage_pipe_pkg::*;

  ins_fields_t     f;
  logic [RA_W-1:0] rs, rt, rd, dest;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic [31:0]     lui_val;
  logic            we, uses_rt, hazard, accept;

  assign f  = split_ins(ins);
  assign rs = RA_W'(f.rs);
  assign rt = RA_W'(f.rt);
  assign rd = RA_W'(f.rd);

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .RA_W(RA_W)) u_regfile (
    .CLK (CLK),
    .RST (RST),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rdata1),
    .rd2 (rdata2),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // Logical immediates zero-extend; LUI and the rest sign-extend to XLEN
  assign lui_val = {f.imm, 16'h0000};

  always_comb begin
    imm = XLEN'($signed(f.imm));
    case (f.op)
      ANDI, ORI, XORI: imm = XLEN'(f.imm);
      LUI:             imm = XLEN'($signed(lui_val));
      default:         ;
    endcase
  end

  always_comb begin
    dest = rt;
    if (f.op == JAL)         dest = RA_W'(NREG - 1);
    else if (f.op == R_FORM) dest = rd;
  end

  always_comb begin
    we = 1'b1;
    case (f.op)
      SW, BEQ, BNE, J: we = 1'b0;
      R_FORM:          we = (f.funct != JR);
      default:         ;
    endcase
    if (dest == '0) we = 1'b0;
  end

  assign uses_rt  = (f.op == R_FORM) || (f.op == BEQ) || (f.op == BNE) || (f.op == SW);
  assign hazard   = ex_ld && (ex_rt != '0) &&
                    ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid  <= 1'b0;
      out_rdata1 <= '0;
      out_rdata2 <= '0;
      out_imm    <= '0;
      out_pc4    <= '0;
      out_wadr   <= '0;
      out_we     <= 1'b0;
      out_op     <= '0;
      out_funct  <= '0;
      out_shamt  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_rdata1 <= rdata1;
      out_rdata2 <= rdata2;
      out_imm    <= imm;
      out_pc4    <= in_pc4;
      out_wadr   <= dest;
      out_we     <= we;
      out_op     <= f.op;
      out_funct  <= f.funct;
      out_shamt  <= f.shamt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed and randomized checks of id_stage_pipe against a reference model
module tb_id_stage_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] ins = '0;
  logic [31:0] in_pc4 = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_ld = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rdata1, out_rdata2, out_imm, out_pc4;
  logic [4:0]  out_wadr;
  logic        out_we;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_shamt;

  int pass_cnt = 0;
  int total_cnt = 0;

  id_stage_pipe #(.XLEN(32), .NREG(32), .RA_W(5)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
    .in_pc4(in_pc4), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ld(ex_ld), .ex_rt(ex_rt), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_imm(out_imm), .out_pc4(out_pc4), .out_wadr(out_wadr), .out_we(out_we),
    .out_op(out_op), .out_funct(out_funct), .out_shamt(out_shamt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural register array plus the expected ID/EX contents
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata1 = '0, m_rdata2 = '0, m_imm = '0, m_pc4 = '0;
  logic [4:0]  m_wadr = '0, m_shamt = '0;
  logic        m_we = 1'b0;
  logic [5:0]  m_op = '0, m_funct = '0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_imm_of(input logic [31:0] w);
    int unsigned u = w[15:0];
    int          s = (u >= 32768) ? int'(u) - 65536 : int'(u);
    case (w[31:26])
      6'h0C, 6'h0D, 6'h0E: return u;
      6'h0F:               return u * 65536;
      default:             return s;
    endcase
  endfunction

  function automatic logic [4:0] m_dest_of(input logic [31:0] w);
    if (w[31:26] == 6'h03) return 5'd31;
    if (w[31:26] == 6'h00) return w[15:11];
    return w[20:16];
  endfunction

  function automatic logic m_we_of(input logic [31:0] w);
    logic [5:0] op = w[31:26];
    if (op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02) return 1'b0;
    if (op == 6'h00 && w[5:0] == 6'h08) return 1'b0;
    return m_dest_of(w) != 0;
  endfunction

  function automatic logic m_ready();
    logic [5:0] op = ins[31:26];
    logic rt_used = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
    logic haz = ex_ld && ex_rt != 0 &&
                (ex_rt == ins[25:21] || (rt_used && ex_rt == ins[20:16]));
    return (!m_valid || out_ready) && !haz && !flush;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 0; m_rdata1 = 0; m_rdata2 = 0; m_imm = 0; m_pc4 = 0;
      m_wadr = 0; m_we = 0; m_op = 0; m_funct = 0; m_shamt = 0;
    end else begin
      if (flush) m_valid = 0;
      else if (in_valid && m_ready()) begin
        m_valid  = 1;
        m_rdata1 = m_read(ins[25:21]);
        m_rdata2 = m_read(ins[20:16]);
        m_imm    = m_imm_of(ins);
        m_pc4    = in_pc4;
        m_wadr   = m_dest_of(ins);
        m_we     = m_we_of(ins);
        m_op     = ins[31:26];
        m_funct  = ins[5:0];
        m_shamt  = ins[10:6];
      end else if (out_ready) m_valid = 0;
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
  end

  always @(negedge CLK) begin
    chk("in_ready",   64'(in_ready),   64'(m_ready()));
    chk("out_valid",  64'(out_valid),  64'(m_valid));
    chk("out_rdata1", 64'(out_rdata1), 64'(m_rdata1));
    chk("out_rdata2", 64'(out_rdata2), 64'(m_rdata2));
    chk("out_imm",    64'(out_imm),    64'(m_imm));
    chk("out_pc4",    64'(out_pc4),    64'(m_pc4));
    chk("out_wadr",   64'(out_wadr),   64'(m_wadr));
    chk("out_we",     64'(out_we),     64'(m_we));
    chk("out_op",     64'(out_op),     64'(m_op));
    chk("out_funct",  64'(out_funct),  64'(m_funct));
    chk("out_shamt",  64'(out_shamt),  64'(m_shamt));
  end

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd3, funct};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
    logic [5:0] fns [4]  = '{6'h08, 6'h09, 6'h20, 6'h22};
    logic [31:0] r = $urandom;
    logic [5:0] op = ops[$urandom_range(0, 13)];
    logic [5:0] fn = ($urandom_range(0, 3) == 0) ? r[5:0] : fns[$urandom_range(0, 3)];
    if ($urandom_range(0, 15) == 0) op = r[31:26];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[15:6], fn};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (2) step();
    RST = 1'b0;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_imm",   64'(out_imm),   64'd0);

    wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
    step();
    wb_en = 0; out_ready = 1; in_valid = 1; in_pc4 = 32'h104;
    ins = i_ins(6'h08, 5'd5, 5'd6, 16'h8001);
    step();
    chk("addi_rs5", 64'(out_rdata1), 64'h1234);
    chk("addi_imm", 64'(out_imm),    64'hFFFF8001);
    chk("addi_pc4", 64'(out_pc4),    64'h104);

    wb_en = 1; wb_addr = 0; wb_data = 7;
    ins = i_ins(6'h08, 5'd0, 5'd3, 16'h0001);
    step();
    chk("reg0_bypass", 64'(out_rdata1), 64'd0);
    wb_en = 0;
    ins = i_ins(6'h0D, 5'd0, 5'd3, 16'h8001);
    step();
    chk("reg0_read", 64'(out_rdata1), 64'd0);
    chk("ori_imm",   64'(out_imm),    64'h00008001);
    ins = i_ins(6'h0F, 5'd0, 5'd4, 16'h1234);
    step();
    chk("lui_imm", 64'(out_imm), 64'h12340000);
    ins = {6'h03, 26'h0000100};
    step();
    chk("jal_wadr", 64'(out_wadr), 64'd31);
    chk("jal_we",   64'(out_we),   64'd1);
    ins = r_ins(5'd1, 5'd2, 5'd8, 6'h20);
    step();
    chk("add_wadr", 64'(out_wadr), 64'd8);
    chk("add_we",   64'(out_we),   64'd1);
    ins = i_ins(6'h2B, 5'd1, 5'd2, 16'h0010);
    step();
    chk("sw_we", 64'(out_we), 64'd0);
    ins = r_ins(5'd31, 5'd0, 5'd0, 6'h08);
    step();
    chk("jr_we", 64'(out_we), 64'd0);

    wb_en = 1; wb_addr = 9; wb_data = 32'hAA;
    ins = r_ins(5'd9, 5'd2, 5'd3, 6'h20);
    step();
    chk("bypass_rs9", 64'(out_rdata1), 64'hAA);
    wb_en = 0;

    ex_ld = 1; ex_rt = 10;
    ins = r_ins(5'd10, 5'd2, 5'd3, 6'h20);
    #1;
    chk("hazard_ready", 64'(in_ready), 64'd0);
    step();
    chk("hazard_drop", 64'(out_valid), 64'd0);
    ex_ld = 0;
    #1;
    chk("hazard_clear", 64'(in_ready), 64'd1);
    step();
    chk("hazard_accept", 64'(out_valid), 64'd1);
    chk("hazard_rs10",   64'(out_rdata1), 64'd0);

    out_ready = 0;
    ins = i_ins(6'h08, 5'd5, 5'd7, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 64'(in_ready), 64'd0);
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_wadr",  64'(out_wadr),  64'd3);
    end

    out_ready = 1; flush = 1;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush = 0; in_valid = 0;
    step();
    chk("flush_noacc", 64'(out_valid), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      ins       = rand_ins();
      in_pc4    = $urandom;
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      ex_ld     = ($urandom_range(0, 3) == 0);
      ex_rt     = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      RST       = (c == 1500);
      step();
    end
    RST = 0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
